// File: rtl/hour_disp_pkg.sv
// Shared constants for the hour display driver: active-high glyphs, slot selects, legal hour range.
package hour_disp_pkg;

  localparam logic [6:0] GLYPH_0    = 7'h3F;
  localparam logic [6:0] GLYPH_1    = 7'h06;
  localparam logic [6:0] GLYPH_2    = 7'h5B;
  localparam logic [6:0] GLYPH_3    = 7'h4F;
  localparam logic [6:0] GLYPH_4    = 7'h66;
  localparam logic [6:0] GLYPH_5    = 7'h6D;
  localparam logic [6:0] GLYPH_6    = 7'h7D;
  localparam logic [6:0] GLYPH_7    = 7'h07;
  localparam logic [6:0] GLYPH_8    = 7'h7F;
  localparam logic [6:0] GLYPH_9    = 7'h6F;
  localparam logic [6:0] GLYPH_DASH = 7'h40;
  localparam logic [6:0] GLYPH_OFF  = 7'h00;

  typedef enum logic {
    SEL_ONES = 1'b0,
    SEL_TENS = 1'b1
  } sel_e;

  localparam logic [3:0] HOUR_MIN = 4'd1;
  localparam logic [3:0] HOUR_MAX = 4'd12;

endpackage

// File: rtl/hour_disp_seg7_enc.sv
// Combinational BCD digit to active-high seven-segment glyph; digits above 9 render dark.
// Zero latency, no flow control.
module seg7_enc
  import hour_disp_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] glyph
);

  always_comb begin
    glyph = GLYPH_OFF;
    case (digit)
      4'd0: glyph = GLYPH_0;
      4'd1: glyph = GLYPH_1;
      4'd2: glyph = GLYPH_2;
      4'd3: glyph = GLYPH_3;
      4'd4: glyph = GLYPH_4;
      4'd5: glyph = GLYPH_5;
      4'd6: glyph = GLYPH_6;
      4'd7: glyph = GLYPH_7;
      4'd8: glyph = GLYPH_8;
      4'd9: glyph = GLYPH_9;
      default: glyph = GLYPH_OFF;
    endcase
  end

endmodule

// File: rtl/hour_disp_drv.sv
// Two-digit multiplexed hour display driver with range check and sticky error; display lags capture by one edge.
// No backpressure: every hour_vld strobe is consumed on the edge it is seen.
module hour_disp_drv
  import hour_disp_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int ACTIVE_LOW_SEG = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hour_in,
  input  logic       hour_vld,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int             CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]     POL_MASK = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;

  logic [3:0]       hour_q;
  logic [CNT_W-1:0] div_cnt;
  sel_e             sel;
  logic             hour_ok;
  logic             tens;
  logic [3:0]       ones;
  logic [6:0]       ones_glyph;
  logic [6:0]       nxt_glyph;
  logic [1:0]       nxt_an;

  assign hour_ok = (hour_in >= HOUR_MIN) && (hour_in <= HOUR_MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hour_q <= HOUR_MIN;
      err    <= 1'b0;
    end else if (hour_vld) begin
      if (hour_ok) begin
        hour_q <= hour_in;
        err    <= 1'b0;
      end else begin
        err    <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      sel     <= SEL_ONES;
    end else if (div_cnt == CNT_MAX) begin
      div_cnt <= '0;
      sel     <= (sel == SEL_ONES) ? SEL_TENS : SEL_ONES;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tens = (hour_q >= 4'd10);
  assign ones = tens ? (hour_q - 4'd10) : hour_q;

  seg7_enc u_ones_enc (
    .digit (ones),
    .glyph (ones_glyph)
  );

  // Only one anode is ever driven low per slot, so 12 -> 1 can never light both digits.
  always_comb begin
    nxt_an    = 2'b11;
    nxt_glyph = GLYPH_OFF;
    if (sel == SEL_ONES) begin
      nxt_an    = 2'b10;
      nxt_glyph = err ? GLYPH_DASH : ones_glyph;
    end else if (tens && !err) begin
      nxt_an    = 2'b01;
      nxt_glyph = GLYPH_1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 2'b11;
      seg <= GLYPH_OFF ^ POL_MASK;
    end else begin
      an  <= nxt_an;
      seg <= nxt_glyph ^ POL_MASK;
    end
  end

endmodule

// File: tb/tb_hour_disp_drv.sv
// Randomised and directed bench for hour_disp_drv against a cycle-count based display model.
module tb_hour_disp_drv;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] hour_in = 4'd0;
  logic       hour_vld = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int n_tests = 0;
  int n_fail  = 0;

  hour_disp_drv #(.REFRESH_DIV(4), .ACTIVE_LOW_SEG(1)) dut (
    .clk      (clk),
    .reset    (reset),
    .hour_in  (hour_in),
    .hour_vld (hour_vld),
    .seg      (seg),
    .an       (an),
    .err      (err)
  );

  always #5 clk = ~clk;

  // active-low glyphs for digits 0..9
  logic [6:0] glyph_al [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  int         m_n;
  int         m_hour;
  bit         m_err;
  logic [1:0] exp_an;
  logic [6:0] exp_seg;

  // Model: slot follows from the number of edges since reset release; display uses the hour before this edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_n     <= 0;
      m_hour  <= 1;
      m_err   <= 1'b0;
      exp_an  <= 2'b11;
      exp_seg <= 7'h7F;
    end else begin
      m_n <= m_n + 1;
      if (((m_n / 4) % 2) == 0) begin
        exp_an  <= 2'b10;
        exp_seg <= m_err ? 7'h3F : glyph_al[m_hour % 10];
      end else if ((m_hour / 10) == 1 && !m_err) begin
        exp_an  <= 2'b01;
        exp_seg <= glyph_al[1];
      end else begin
        exp_an  <= 2'b11;
        exp_seg <= 7'h7F;
      end
      if (hour_vld) begin
        if (hour_in >= 4'd1 && hour_in <= 4'd12) begin
          m_hour <= int'(hour_in);
          m_err  <= 1'b0;
        end else begin
          m_err  <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, want, $time);
    end
  endtask

  task automatic check_outputs();
    check("an", 32'(an), 32'(exp_an));
    check("seg", 32'(seg), 32'(exp_seg));
    check("err", 32'(err), 32'(m_err));
    check("an_not_00", 32'(an == 2'b00), 32'd0);
  endtask

  task automatic cyc(input bit v, input logic [3:0] h);
    hour_vld = v;
    hour_in  = h;
    @(negedge clk);
    hour_vld = 1'b0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0);
  endtask

  // Reset asserted between edges must clear the outputs before any clock edge.
  task automatic mid_reset();
    #2 reset = 1'b0;
    #1;
    check("rst_an", 32'(an), 32'h3);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_err", 32'(err), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_an", 32'(an), 32'h3);
    check("reset_seg", 32'(seg), 32'h7F);
    check("reset_err", 32'(err), 32'h0);
    reset = 1'b1;

    idle(8);
    cyc(1'b1, 4'd12); idle(9);
    cyc(1'b1, 4'd9);  idle(8);
    cyc(1'b1, 4'd13); idle(8);
    cyc(1'b1, 4'd5);  idle(8);

    cyc(1'b1, 4'd12); idle(5);
    mid_reset();
    idle(8);

    for (int h = 1; h <= 13; h++) begin
      cyc(1'b1, 4'((h > 12) ? 1 : h));
      idle(7);
    end

    cyc(1'b1, 4'd11); cyc(1'b1, 4'd0); cyc(1'b1, 4'd10); idle(8);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) mid_reset();
      else cyc($urandom_range(3) == 0, 4'($urandom_range(15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hour_disp_drv.md
# hour_disp_drv

Display driver for the 12-hour counter: it accepts a 4-bit hour value (1..12), splits it into tens and ones digits, and time-multiplexes two common-anode seven-segment digits. It sits downstream of the hour counter, on the board display interface.
- Leading-zero tens digit is blanked.
- Out-of-range inputs are rejected: a sticky error flag is raised and a dash is shown.

## Interface
- REFRESH_DIV, 50000, clk cycles per digit slot; must be >= 2.
- ACTIVE_LOW_SEG, 1, 1 means segment outputs are inverted (lit = 0).

- clk  input  1  single system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- hour_in  input  4  hour value, legal range 1..12.
- hour_vld  input  1  capture strobe; hour_in is sampled on each clk edge where this is 1.
- seg  output  7  segments {g,f,e,d,c,b,a}, bit0 = a, polarity per ACTIVE_LOW_SEG.
- an  output  2  digit enables, active-low; an[0] = ones, an[1] = tens.
- err  output  1  sticky invalid-input flag.

## Operation
- **Hour register.** hour_vld=1 with hour_in in 1..12 loads hour_q and clears err. hour_vld=1 with hour_in in {0, 13, 14, 15} leaves hour_q unchanged and sets err. hour_vld=0 holds both.
- **Digit split.** tens = (hour_q >= 10); ones = tens ? hour_q - 10 : hour_q. Widths: tens is 1 bit, ones is 4 bits.
- **Refresh counter.** div_cnt counts 0..REFRESH_DIV-1 and wraps to 0. Its width is clog2(REFRESH_DIV). At the wrap, sel toggles: 0 = ones slot, 1 = tens slot.
- **Slot output (registered):**
  - Ones slot, err=0: an=2'b10, seg = glyph(ones).
  - Ones slot, err=1: an=2'b10, seg = dash (g only).
  - Tens slot, tens=1 and err=0: an=2'b01, seg = glyph(1).
  - Tens slot, tens=0 or err=1: an=2'b11, seg = off.
- **Glyphs, active-high:** 0=7'h3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, dash=40, off=00. When ACTIVE_LOW_SEG=1 every pattern is bitwise inverted (e.g. 1=79, 2=24, 5=12, 9=10, dash=3F, off=7F).
- **Reset values:**
  - hour_q=1, err=0, div_cnt=0, sel=0.
  - an=2'b11, seg=off (all segments dark).
- **Reset mid-operation:** asserting reset forces all reset values immediately, without waiting for a clock edge.

## Timing
- Capture-to-display latency:
  - hour_q and err update on the edge where hour_vld=1.
  - seg and an reflect the new value one edge later, in whichever slot is active.
- First edge after reset release: an=2'b10 and seg shows the ones glyph of hour_q=1.
- Slot length is exactly REFRESH_DIV cycles; the full refresh period is 2*REFRESH_DIV cycles.
- **hour_vld on the same edge as a slot toggle:** the new slot uses the new hour_q value from its first displayed cycle, with one edge of latency.
- **Back-to-back strobes:** the last strobe wins. Every strobe is evaluated independently for err.
- **Input wrap 12 -> 1:**
  - The tens digit goes from lit to blank on the next tens slot.
  - No glitch cycle with both an bits low. an never equals 2'b00.

## Structure
- **Package hour_disp_pkg:**
  - Active-high glyph constants GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_OFF.
  - Slot select constants SEL_ONES=0, SEL_TENS=1.
  - HOUR_MIN=1, HOUR_MAX=12.
- **Sub-module seg7_enc:** combinational 4-bit digit to 7-bit active-high glyph. Values above 9 map to GLYPH_OFF. Polarity inversion is applied in hour_disp_drv.

## Test plan
All tests use REFRESH_DIV=4 and ACTIVE_LOW_SEG=1.
- **Reset release:**
  - During reset: an=11, seg=7F, err=0.
  - Cycles 1-4 after release: an=10, seg=79.
  - Cycles 5-8: an=11, seg=7F (tens blanked).
- **hour_in=12 with hour_vld pulse:**
  - Ones slot: an=10, seg=24.
  - Tens slot: an=01, seg=79.
  - Display updates one edge after capture.
- **hour_in=9:** ones slot seg=10; tens slot an=11, seg=7F.
- **hour_in=13 with hour_vld:**
  - err=1 on the next cycle; ones slot seg=3F; tens slot blank.
  - Then hour_in=5 with hour_vld: err=0, ones slot seg=12.
- **Reset asserted mid-slot while showing 12:**
  - Same cycle, asynchronously: an=11, seg=7F, err=0.
  - After release the display shows 1.
- **Sweep hour_in 1..12 then 1, strobe every 8 cycles:**
  - Every ones and tens slot matches the digit split.
  - an is never 00.
  - Slot lengths are exactly 4 cycles.
